// File: rtl/imm_decode_if.sv
// imm_decode_if: instruction-in / decoded-fields-out handshake bundle for
// imm_decode_stage. master = producer/consumer side, slave = the stage.
interface imm_decode_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_imm;
    logic             out_sext;
    logic             out_has_imm;
    logic             out_illegal;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [7:0]       illegal_cnt;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_sext, out_has_imm,
               out_illegal, out_rs, out_rt, illegal_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_sext, out_has_imm,
               out_illegal, out_rs, out_rt, illegal_cnt
    );
endinterface

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decodes the immediate field and extend select of a MIPS
// instruction and holds it for the immediate extender behind a 2-entry skid
// buffer (EMPTY/ONE/TWO). in_ready depends on registered state only, so there
// is no combinational path from out_ready to in_ready.
// WIDTH (legal 1..16) selects instr[WIDTH-1:0] as the immediate field.
// Optional feature: define IMM_DECODE_ILLEGAL_CNT_EN to build a saturating
// 8-bit counter of illegal words leaving the stage; otherwise illegal_cnt = 0.
module imm_decode_stage #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_decode_if.slave  bus
);

    typedef struct packed {
        logic [WIDTH-1:0] imm;
        logic             sext;
        logic             has_imm;
        logic             illegal;
        logic [4:0]       rs;
        logic [4:0]       rt;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_dec;
    logic   in_fire;
    logic   out_fire;

    // Opcode decode done at load time so the buffered entries are final.
    function automatic entry_t decode(input logic [31:0] instr);
        entry_t e;
        e    = '0;
        e.rs = instr[25:21];
        e.rt = instr[20:16];
        case (instr[31:26])
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b100011, 6'b101011, 6'b000100, 6'b000101: begin
                e.sext    = 1'b1;
                e.has_imm = 1'b1;
            end
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                e.has_imm = 1'b1;
            end
            6'b000000, 6'b000010, 6'b000011: begin
                e.has_imm = 1'b0;
            end
            default: begin
                e.illegal = 1'b1;
            end
        endcase
        // Words without an immediate present zero to the extender.
        if (e.has_imm) e.imm = instr[WIDTH-1:0];
        return e;
    endfunction

    assign in_dec   = decode(bus.in_instr);
    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    assign bus.in_ready    = rst_n & (state != TWO);
    assign bus.out_valid   = (state != EMPTY);
    assign bus.out_imm     = main_q.imm;
    assign bus.out_sext    = main_q.sext;
    assign bus.out_has_imm = main_q.has_imm;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_rs      = main_q.rs;
    assign bus.out_rt      = main_q.rt;

    // Skid-buffer FSM: main feeds the outputs, skid catches one word of backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_dec;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_dec;
                    end else if (in_fire) begin
                        skid_q <= in_dec;
                        state  <= TWO;
                    end else if (out_fire) begin
                        state  <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef IMM_DECODE_ILLEGAL_CNT_EN
    logic [7:0] cnt_q;

    // Count illegal words as they leave; stick at 8'hFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
        end else if (out_fire && main_q.illegal && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.illegal_cnt = cnt_q;
`else
    assign bus.illegal_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed table, backpressure/reset sequences and random
// streaming against a queue-based reference of the stage.
module tb_imm_decode_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] imm;
        logic        sext;
        logic        has;
        logic        ill;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   vecs  = 0;
    int   fails = 0;

    imm_decode_if #(.WIDTH(16)) bus ();

    imm_decode_stage #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare and report.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the opcode lists, by opcode number.
    function automatic vec_t ref_decode(input logic [31:0] w);
        vec_t v;
        int   op;
        op     = int'(w[31:26]);
        v      = '0;
        v.instr = w;
        v.rs   = w[25:21];
        v.rt   = w[20:16];
        if (op inside {8, 9, 10, 11, 35, 43, 4, 5}) begin
            v.sext = 1'b1;
            v.has  = 1'b1;
        end else if (op >= 12 && op <= 15) begin
            v.has = 1'b1;
        end else if (!(op inside {0, 2, 3})) begin
            v.ill = 1'b1;
        end
        if (v.has) v.imm = w[15:0];
        return v;
    endfunction

    function automatic logic [28:0] fields(input vec_t v);
        return {v.imm, v.sext, v.has, v.ill, v.rs, v.rt};
    endfunction

    function automatic logic [28:0] dut_fields();
        return {bus.out_imm, bus.out_sext, bus.out_has_imm, bus.out_illegal,
                bus.out_rs, bus.out_rt};
    endfunction

    function automatic logic [31:0] rand_word();
        int          ops [15] = '{0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[31:26] = 6'(ops[$urandom_range(0, 14)]);
        return w;
    endfunction

    // Scoreboard: queue occupancy is the expected buffer fill.
    vec_t q[$];
    int   cnt_model = 0;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            q.delete();
            cnt_model = 0;
            chk("mon_rst_out_valid", 32'(bus.out_valid), 0);
            chk("mon_rst_in_ready", 32'(bus.in_ready), 0);
        end else begin
            chk("mon_in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
            chk("mon_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
`ifdef IMM_DECODE_ILLEGAL_CNT_EN
            chk("mon_illegal_cnt", 32'(bus.illegal_cnt), 32'(cnt_model));
`else
            chk("mon_illegal_cnt", 32'(bus.illegal_cnt), 0);
`endif
            if (bus.out_valid && q.size() > 0) begin
                chk("mon_fields", 32'(dut_fields()), 32'(fields(q[0])));
                if (bus.out_ready) begin
                    if (q[0].ill && cnt_model < 255) cnt_model++;
                    void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(ref_decode(bus.in_instr));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl [10];
    logic [31:0] bp [4];
    int idx, outs, first, last, acc, seen;

    initial begin
        tbl[0] = '{32'h2008FFF0, 16'hFFF0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd8};  // addi
        tbl[1] = '{32'h3508FFF0, 16'hFFF0, 1'b0, 1'b1, 1'b0, 5'd8, 5'd8};  // ori
        tbl[2] = '{32'h01094020, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9};  // R-type
        tbl[3] = '{32'hFC001234, 16'h0000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0};  // op 111111
        tbl[4] = '{32'h8C8A8000, 16'h8000, 1'b1, 1'b1, 1'b0, 5'd4, 5'd10}; // lw
        tbl[5] = '{32'h3C011234, 16'h1234, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1};  // lui
        tbl[6] = '{32'h0800ABCD, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};  // j
        tbl[7] = '{32'h1109FFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 5'd8, 5'd9};  // beq
        tbl[8] = '{32'h312800FF, 16'h00FF, 1'b0, 1'b1, 1'b0, 5'd9, 5'd8};  // andi
        tbl[9] = '{32'h04011111, 16'h0000, 1'b0, 1'b0, 1'b1, 5'd0, 5'd1};  // op 000001

        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;
        #3 rst_n = 1'b0;

        // Reset state.
        @(negedge clk); #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_fields", 32'(dut_fields()), 0);
        chk("rst_illegal_cnt", 32'(bus.illegal_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(bus.in_ready), 1);

        // Directed table: one word at a time, 1-cycle latency.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_instr  = tbl[i].instr;
            bus.out_ready = 1'b1;
            #1 chk("tbl_in_ready", 32'(bus.in_ready), 1);
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            chk("tbl_latency", 32'(bus.out_valid), 1);
            chk("tbl_fields", 32'(dut_fields()), 32'(fields(tbl[i])));
        end

        // Backpressure: four words with out_ready low, then released.
        for (int i = 0; i < 4; i++) bp[i] = rand_word();
        idx = 0; outs = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 40 && outs < 4; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (idx < 4);
            bus.in_instr  = bp[(idx < 4) ? idx : 3];
            bus.out_ready = (cyc >= 5);
            #1;
            if (cyc == 4) begin
                chk("bp_two_in_ready", 32'(bus.in_ready), 0);
                chk("bp_two_accepted", 32'(idx), 2);
            end
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid && bus.out_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                outs++;
            end
        end
        bus.in_valid = 1'b0;
        chk("bp_all_out", 32'(outs), 4);
        chk("bp_no_gaps", 32'(last - first), 3);

        // Random streaming at full rate.
        @(negedge clk);
        acc = 0; outs = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_instr  = rand_word();
            bus.out_ready = 1'b1;
            #1;
            if (bus.in_valid && bus.in_ready) acc++;
            if (bus.out_valid && bus.out_ready) outs++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("stream_accepted", 32'(acc), 100);
        chk("stream_emitted", 32'(outs), 99);

        // Reset while holding two words.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_instr  = 32'h2008AAA0 + 32'(c);
            bus.out_ready = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("rst_pre_two", 32'(bus.in_ready), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(bus.out_valid), 0);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_in_ready", 32'(bus.in_ready), 1);
        chk("rst_rel_out_valid", 32'(bus.out_valid), 0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1 if (bus.out_valid) seen++;
        end
        chk("rst_no_old_words", 32'(seen), 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = tbl[1].instr;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("rst_new_word", 32'(dut_fields()), 32'(fields(tbl[1])));

        // 300 illegal words to drive the counter into saturation.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_instr  = {(c % 2 == 0) ? 6'h3F : 6'h3E, 26'($urandom)};
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
`ifdef IMM_DECODE_ILLEGAL_CNT_EN
        chk("illegal_cnt_sat", 32'(bus.illegal_cnt), 32'hFF);
`else
        chk("illegal_cnt_off", 32'(bus.illegal_cnt), 0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
